event_tag_fifo: RTL

//  Multi-event buffer between the trigger-tag capture logic and the VME read decoder.
//  On each TRIG2 rising edge, snapshots event tag, spill tag and time stamp, and

---
 rtl/event_tag_fifo_if.sv | 28 ++
 rtl/event_tag_fifo.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/event_tag_fifo_if.sv
// rtl/event_tag_fifo_if.sv - capture/read bus bundle for event_tag_fifo
interface event_tag_fifo_if #(
   parameter int AW = 8
);
   logic        trig;
   logic        lock;
   logic [13:0] enc;
   logic [9:0]  snc;
   logic [31:0] tstamp;
   logic        clr;
   logic        rd_req;
   logic [31:0] rd_data;
   logic        empty;
   logic [AW:0] word_cnt;
   logic        busy;
   logic        overflow;
   logic [15:0] drop_cnt;

   modport master (
      output trig, lock, enc, snc, tstamp, clr, rd_req,
      input  rd_data, empty, word_cnt, busy, overflow, drop_cnt
   );

   modport slave (
      input  trig, lock, enc, snc, tstamp, clr, rd_req,
      output rd_data, empty, word_cnt, busy, overflow, drop_cnt
   );
endinterface

// File: rtl/event_tag_fifo.sv
// rtl/event_tag_fifo.sv - 3-word event record FIFO between trigger capture and VME reads
module event_tag_fifo #(
   parameter int AW          = 8,
   parameter int BUSY_MARGIN = 2
) (
   input logic             clk,
   input logic             RST,
   event_tag_fifo_if.slave bus
);
   typedef enum logic [1:0] {IDLE, WR0, WR1, WR2} state_t;

   localparam int          DEPTH      = 2**AW;
   localparam logic [AW:0] FULL_CNT   = (AW+1)'(DEPTH);
   localparam logic [AW:0] BUSY_TH    = (AW+1)'(3*BUSY_MARGIN);
   localparam logic [AW:0] REC_WORDS  = (AW+1)'(3);
   localparam logic [31:0] EMPTY_WORD = 32'hFEFE_FEFE;

   state_t        state_q, state_d;
   logic          trig_prev_q, trig_prev_d;
   logic [31:0]   w0_q, w0_d, w1_q, w1_d, w2_q, w2_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic [31:0]   rd_data_q, rd_data_d;
   logic          busy_q, busy_d;
   logic          overflow_q, overflow_d;
   logic [15:0]   drop_cnt_q, drop_cnt_d;
   logic [31:0]   mem [DEPTH];

   logic          trig_edge, room, accept, drop, do_pop, mem_we;
   logic [31:0]   mem_wdata;
   logic [AW:0]   free_cnt;
   logic          unused_bits;

   // Only the upper event bits and the low spill byte go into the record.
   assign unused_bits = ^{bus.enc[1:0], bus.snc[9:8]};

   // A record only starts when all three words fit, so full can never be hit mid-record.
   assign trig_edge = bus.trig & ~trig_prev_q;
   assign free_cnt  = FULL_CNT - cnt_q;
   assign room      = (free_cnt >= REC_WORDS);
   assign accept    = trig_edge & ~bus.clr & (state_q == IDLE) & room;
   assign drop      = trig_edge & ~bus.clr & ~accept;
   assign do_pop    = bus.rd_req & ~bus.clr & (cnt_q != '0);

   // State register and all datapath flops; RST wins over everything.
   always_ff @(posedge clk) begin
      if (RST) begin
         state_q     <= IDLE;
         trig_prev_q <= 1'b0;
         w0_q        <= '0;
         w1_q        <= '0;
         w2_q        <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         cnt_q       <= '0;
         rd_data_q   <= '0;
         busy_q      <= 1'b0;
         overflow_q  <= 1'b0;
         drop_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         trig_prev_q <= trig_prev_d;
         w0_q        <= w0_d;
         w1_q        <= w1_d;
         w2_q        <= w2_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         cnt_q       <= cnt_d;
         rd_data_q   <= rd_data_d;
         busy_q      <= busy_d;
         overflow_q  <= overflow_d;
         drop_cnt_q  <= drop_cnt_d;
      end
   end

   // Record storage; contents are don't-care after reset because the pointers gate access.
   always_ff @(posedge clk) begin
      if (mem_we) mem[wr_ptr_q] <= mem_wdata;
   end

   // Write sequencer next state: one word per state, clr aborts a partial record.
   always_comb begin
      state_d = state_q;
      if (bus.clr) begin
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE:    if (accept) state_d = WR0;
            WR0:     state_d = WR1;
            WR1:     state_d = WR2;
            WR2:     state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // Write sequencer outputs: which snapshot word goes into the FIFO this cycle.
   always_comb begin
      mem_we    = 1'b0;
      mem_wdata = w0_q;
      unique case (state_q)
         WR0:     begin mem_we = ~bus.clr; mem_wdata = w0_q; end
         WR1:     begin mem_we = ~bus.clr; mem_wdata = w1_q; end
         WR2:     begin mem_we = ~bus.clr; mem_wdata = w2_q; end
         default: begin mem_we = 1'b0;     mem_wdata = w0_q; end
      endcase
   end

   // Snapshot, pointer, occupancy, read-data and drop bookkeeping.
   always_comb begin
      trig_prev_d = bus.trig;
      w0_d        = w0_q;
      w1_d        = w1_q;
      w2_d        = w2_q;
      if (trig_edge && !bus.clr && state_q == IDLE) begin
         w0_d = {bus.lock, 19'd0, bus.enc[13:2]};
         w1_d = {bus.lock, 23'd0, bus.snc[7:0]};
         w2_d = bus.tstamp;
      end

      rd_data_d = rd_data_q;
      if (bus.rd_req && !bus.clr) rd_data_d = (cnt_q != '0) ? mem[rd_ptr_q] : EMPTY_WORD;

      if (bus.clr) begin
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         cnt_d      = '0;
         overflow_d = 1'b0;
         drop_cnt_d = '0;
      end else begin
         wr_ptr_d   = wr_ptr_q + {{(AW-1){1'b0}}, mem_we};
         rd_ptr_d   = rd_ptr_q + {{(AW-1){1'b0}}, do_pop};
         cnt_d      = cnt_q + {{AW{1'b0}}, mem_we} - {{AW{1'b0}}, do_pop};
         overflow_d = overflow_q | drop;
         drop_cnt_d = (drop && drop_cnt_q != 16'hFFFF) ? drop_cnt_q + 16'd1 : drop_cnt_q;
      end

      busy_d = ((FULL_CNT - cnt_d) < BUSY_TH);
   end

   assign bus.rd_data  = rd_data_q;
   assign bus.empty    = (cnt_q == '0);
   assign bus.word_cnt = cnt_q;
   assign bus.busy     = busy_q;
   assign bus.overflow = overflow_q;
   assign bus.drop_cnt = drop_cnt_q;
endmodule
